divider_check_multiplier: RTL and testbench
===========================================

# divider_check_multiplier

Sequential shift-and-add multiplier that rebuilds a dividend from a quotient, divisor and remainder, computing product = quotient × divisor + remainder. It is the inverse path of the team's combinational divider and is used in self-check and FP normalisation datapaths. It retires N quotient bits per cycle under a valid/ready handshake on both the input and output sides.

## Interface
- QUOTIENTLEN, 16, width of the quotient operand
- DIVISORLEN, 8, width of the divisor and remainder operands
- N, 4, quotient bits consumed per iteration (1 ≤ N ≤ QUOTIENTLEN)
- Derived, not overridable: PRODUCTLEN = QUOTIENTLEN+DIVISORLEN; ITER = ceil(QUOTIENTLEN/N)

- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- quotient  in  QUOTIENTLEN  unsigned multiplier
- divisor  in  DIVISORLEN  unsigned multiplicand
- remainder  in  DIVISORLEN  unsigned addend
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  PRODUCTLEN  quotient×divisor+remainder

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture quotient, divisor and remainder; acc ← zero-extended remainder; cnt ← 0; go to BUSY.
  - BUSY: digit = quotient_reg[N-1:0]; acc ← acc + ((digit × divisor_reg) << (N×cnt)); quotient_reg ← quotient_reg >> N; cnt ← cnt+1. When cnt == ITER-1, go to DONE.
  - DONE: out_valid=1 and product=acc. On out_ready, go to IDLE.
- Arithmetic is unsigned throughout. The partial product is N+DIVISORLEN bits wide.
- The result never overflows: the maximum is (2^QUOTIENTLEN−1)(2^DIVISORLEN−1)+(2^DIVISORLEN−1) = (2^DIVISORLEN−1)·2^QUOTIENTLEN < 2^PRODUCTLEN. Any accumulator carry out of PRODUCTLEN is dropped and must never occur.
- If QUOTIENTLEN is not a multiple of N, the last digit is zero-padded in its upper bits by the right shift.
- The block uses operands only as captured at acceptance. Input changes while BUSY or DONE are ignored.
- in_ready is 1 only in IDLE. While in BUSY or DONE, in_valid is ignored with no queuing.
- divisor=0 is legal and yields product=remainder. The remainder<divisor relation is not checked.

## Timing
- Reset (rst_n=0 at a rising edge) forces state to IDLE, acc=0, cnt=0 and operand registers to 0.
  - Output values during and after reset: in_ready=1, out_valid=0, product=0.
  - Reset takes priority over every other event, including mid-BUSY and mid-DONE; the operation in progress is discarded.
- Handshake transfers occur on rising edges where valid&&ready=1.
- Latency: acceptance at edge E0 → ITER BUSY edges → out_valid is high after edge E0+ITER. With defaults, ITER=4.
- product is stable and held while out_valid=1 and out_ready=0, for any number of cycles.
- Output transfer at edge Ek → in_ready=1 after Ek. The next acceptance is possible at Ek+1.
  - Throughput: one result per ITER+2 cycles at best.
- out_valid=1 never coexists with in_ready=1.
- out_ready asserted outside DONE has no effect.

## Structure
- Shared package divider_pkg holds:
  - the state enum typedef (IDLE, BUSY, DONE);
  - a function computing ITER from QUOTIENTLEN and N;
  - a function computing the counter width as $clog2(ITER+1).
- One natural sub-module is digit_mac: a combinational N×DIVISORLEN partial-product generator plus shifted add into a PRODUCTLEN accumulator, parameterised by N, DIVISORLEN, PRODUCTLEN, with the shift amount as an input.
- The top level holds the FSM, counter, operand registers and handshake.

## Test plan
- Nominal: quotient=0x1234, divisor=0x56, remainder=0x21, out_ready=1 → out_valid high exactly 4 cycles after acceptance, product=0x061D99, in_ready low until one cycle after the output transfer.
- Maximum: quotient=0xFFFF, divisor=0xFF, remainder=0xFF → product=0xFF0000, no wrap.
- Zero divisor: quotient=0xABCD, divisor=0x00, remainder=0x05 → product=0x000005. Also quotient=0, divisor=0x7F, remainder=0 → product=0.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid rises while toggling in_valid and the operand inputs → product constant, in_ready=0, no second capture. Release out_ready → exactly one transfer.
- Reset mid-operation: assert rst_n=0 on the 2nd BUSY cycle → after that edge out_valid=0, in_ready=1, product=0. A following operation of 3×7+2 gives product=0x000017.
- Round trip: 1000 random (dividend, nonzero divisor) pairs fed through the team's divider, then its quotient and remainder fed here → product equals the zero-extended dividend. Repeat with N=1, N=3 (non-dividing, ITER=6) and N=16 (ITER=1).

Source files
------------

// File: rtl/divider_pkg.sv
// divider_pkg
//   Shared types and sizing helpers for the divider family of blocks.
//   - state_e     : control state of the sequential check multiplier
//   - calc_iter   : number of digit iterations needed to consume a quotient
//   - calc_cnt_w  : width of an iteration counter that can hold 0..iter
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // ceil(qlen / n): a partial last digit still costs a full iteration.
  function automatic int calc_iter(input int qlen, input int n);
    return (qlen + n - 1) / n;
  endfunction

  function automatic int calc_cnt_w(input int iter);
    return $clog2(iter + 1);
  endfunction

endpackage

// File: rtl/divider_check_multiplier_digit_mac.sv
// digit_mac
//   Combinational digit multiply-accumulate: forms the N x DIVISORLEN partial
//   product of one quotient digit and the divisor, shifts it to the digit's
//   weight and adds it into the running product.
//   Ports:
//     digit   in  N           current quotient digit (unsigned)
//     divisor in  DIVISORLEN  multiplicand (unsigned)
//     shamt   in  SH_W        left shift applied to the partial product
//     acc_in  in  PRODUCTLEN  running accumulator
//     acc_out out PRODUCTLEN  acc_in + (digit*divisor << shamt), carry dropped
module digit_mac #(
  parameter int N          = 4,
  parameter int DIVISORLEN = 8,
  parameter int PRODUCTLEN = 24,
  parameter int SH_W       = 6
) (
  input  logic [N-1:0]          digit,
  input  logic [DIVISORLEN-1:0] divisor,
  input  logic [SH_W-1:0]       shamt,
  input  logic [PRODUCTLEN-1:0] acc_in,
  output logic [PRODUCTLEN-1:0] acc_out
);

  localparam int PP_W = N + DIVISORLEN;

  logic [PP_W-1:0]       pp;
  logic [PRODUCTLEN-1:0] pp_ext;

  always_comb begin
    pp      = PP_W'(digit) * PP_W'(divisor);
    pp_ext  = PRODUCTLEN'(pp);
    // The full result provably fits PRODUCTLEN, so the adder carry is dropped.
    acc_out = acc_in + (pp_ext << shamt);
  end

endmodule

// File: rtl/divider_check_multiplier.sv
// divider_check_multiplier
//   Sequential shift-and-add multiplier rebuilding a dividend as
//   product = quotient * divisor + remainder, N quotient bits per cycle.
//   Ports:
//     clk       in   1            rising-edge clock
//     rst_n     in   1            synchronous active-low reset
//     in_valid  in   1            operands valid
//     in_ready  out  1            block idle and able to accept operands
//     quotient  in   QUOTIENTLEN  unsigned multiplier
//     divisor   in   DIVISORLEN   unsigned multiplicand
//     remainder in   DIVISORLEN   unsigned addend
//     out_valid out  1            product valid
//     out_ready in   1            consumer accepts product
//     product   out  PRODUCTLEN   quotient*divisor+remainder
module divider_check_multiplier
  import divider_pkg::*;
#(
  parameter int QUOTIENTLEN = 16,
  parameter int DIVISORLEN  = 8,
  parameter int N           = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [QUOTIENTLEN-1:0]              quotient,
  input  logic [DIVISORLEN-1:0]               divisor,
  input  logic [DIVISORLEN-1:0]               remainder,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [QUOTIENTLEN+DIVISORLEN-1:0]   product
);

  localparam int PRODUCTLEN = QUOTIENTLEN + DIVISORLEN;
  localparam int ITER       = calc_iter(QUOTIENTLEN, N);
  localparam int CNT_W      = calc_cnt_w(ITER);
  localparam int SH_W       = $clog2(PRODUCTLEN) + 1;

  state_e                 state_q, state_d;
  logic [QUOTIENTLEN-1:0] quot_q, quot_d;
  logic [DIVISORLEN-1:0]  div_q, div_d;
  logic [PRODUCTLEN-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [SH_W-1:0]        shamt;
  logic [PRODUCTLEN-1:0]  mac_acc;

  // Digit cnt carries weight 2^(N*cnt).
  assign shamt = SH_W'(N) * SH_W'(cnt_q);

  digit_mac #(
    .N          (N),
    .DIVISORLEN (DIVISORLEN),
    .PRODUCTLEN (PRODUCTLEN),
    .SH_W       (SH_W)
  ) u_digit_mac (
    .digit   (quot_q[N-1:0]),
    .divisor (div_q),
    .shamt   (shamt),
    .acc_in  (acc_q),
    .acc_out (mac_acc)
  );

  always_comb begin
    state_d = state_q;
    quot_d  = quot_q;
    div_d   = div_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          quot_d  = quotient;
          div_d   = divisor;
          // Seeding with the remainder saves a final add cycle.
          acc_d   = PRODUCTLEN'(remainder);
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d  = mac_acc;
        // The shift zero-fills, padding a short final digit.
        quot_d = quot_q >> N;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      quot_q  <= '0;
      div_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      div_q   <= div_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;

endmodule

// File: tb/tb_divider_check_multiplier.sv
module tb_divider_check_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;

  // Default-parameter DUT (N=4, ITER=4)
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] quotient;
  logic [7:0]  divisor, remainder;
  logic [23:0] product;

  // Shared stimulus for the N=1 / N=3 / N=16 variants
  logic        x_in_valid, x_out_ready;
  logic [15:0] x_quotient;
  logic [7:0]  x_divisor, x_remainder;
  logic        rdy_1, rdy_3, rdy_16;
  logic        ov_1, ov_3, ov_16;
  logic [23:0] prod_1, prod_3, prod_16;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  divider_check_multiplier dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .quotient(quotient), .divisor(divisor), .remainder(remainder),
    .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  divider_check_multiplier #(.QUOTIENTLEN(16), .DIVISORLEN(8), .N(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(rdy_1),
    .quotient(x_quotient), .divisor(x_divisor), .remainder(x_remainder),
    .out_valid(ov_1), .out_ready(x_out_ready), .product(prod_1)
  );

  divider_check_multiplier #(.QUOTIENTLEN(16), .DIVISORLEN(8), .N(3)) dut_n3 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(rdy_3),
    .quotient(x_quotient), .divisor(x_divisor), .remainder(x_remainder),
    .out_valid(ov_3), .out_ready(x_out_ready), .product(prod_3)
  );

  divider_check_multiplier #(.QUOTIENTLEN(16), .DIVISORLEN(8), .N(16)) dut_n16 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(rdy_16),
    .quotient(x_quotient), .divisor(x_divisor), .remainder(x_remainder),
    .out_valid(ov_16), .out_ready(x_out_ready), .product(prod_16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_wait", 64'(in_ready), 64'd1);
  endtask

  // One operation on the default DUT with out_ready held high.
  task automatic run_op(input string tag, input logic [15:0] q, input logic [7:0] d,
                        input logic [7:0] r, input logic [23:0] exp);
    wait_ready();
    quotient = q; divisor = d; remainder = r;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();                                   // acceptance edge E0
    in_valid = 1'b0;
    chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    tick(); tick(); tick();                   // E0+3
    chk({tag, "_early_valid"}, 64'(out_valid), 64'd0);
    tick();                                   // E0+4
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
    chk({tag, "_product"}, 64'(product), 64'(exp));
    tick();                                   // output transfer edge
    chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_post_ready"}, 64'(in_ready), 64'd1);
  endtask

  // One operation fed to the N=1/3/16 variants at once; each has its own latency.
  task automatic run_multi(input string tag, input logic [15:0] q, input logic [7:0] d,
                           input logic [7:0] r, input logic [23:0] exp);
    bit s1 = 0, s3 = 0, s16 = 0;
    chk({tag, "_all_ready"}, 64'(rdy_1 & rdy_3 & rdy_16), 64'd1);
    x_quotient = q; x_divisor = d; x_remainder = r;
    x_in_valid = 1'b1; x_out_ready = 1'b1;
    tick();
    x_in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ov_1 && !s1) begin
        s1 = 1;
        chk({tag, "_n1_latency"}, 64'(k), 64'd16);
        chk({tag, "_n1_product"}, 64'(prod_1), 64'(exp));
      end
      if (ov_3 && !s3) begin
        s3 = 1;
        chk({tag, "_n3_latency"}, 64'(k), 64'd6);
        chk({tag, "_n3_product"}, 64'(prod_3), 64'(exp));
      end
      if (ov_16 && !s16) begin
        s16 = 1;
        chk({tag, "_n16_latency"}, 64'(k), 64'd1);
        chk({tag, "_n16_product"}, 64'(prod_16), 64'(exp));
      end
    end
    chk({tag, "_all_seen"}, {61'd0, s1, s3, s16}, 64'd7);
  endtask

  initial begin
    logic [23:0] dividend;
    logic [7:0]  dv;

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    quotient = '0; divisor = '0; remainder = '0;
    x_in_valid = 1'b0; x_out_ready = 1'b1;
    x_quotient = '0; x_divisor = '0; x_remainder = '0;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed vectors
    run_op("nominal", 16'h1234, 8'h56, 8'h21, 24'h061D99);
    run_op("maximum", 16'hFFFF, 8'hFF, 8'hFF, 24'hFF0000);
    run_op("zero_div", 16'hABCD, 8'h00, 8'h05, 24'h000005);
    run_op("zero_all", 16'h0000, 8'h7F, 8'h00, 24'h000000);

    // Backpressure: hold the result while the inputs churn
    wait_ready();
    quotient = 16'h0100; divisor = 8'h03; remainder = 8'h01;   // 256*3+1 = 0x301
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("bp_valid_rise", 64'(out_valid), 64'd1);
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      quotient = 16'($urandom); divisor = 8'($urandom); remainder = 8'($urandom);
      tick();
      chk("bp_product_hold", 64'(product), 64'h301);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    tick(); tick(); tick(); tick(); tick();
    chk("bp_no_second", 64'(out_valid), 64'd0);
    chk("bp_still_idle", 64'(in_ready), 64'd1);

    // Reset during the second BUSY cycle
    wait_ready();
    quotient = 16'h9999; divisor = 8'hAA; remainder = 8'h11;
    in_valid = 1'b1;
    tick();                 // E0
    in_valid = 1'b0;
    tick();                 // E1
    rst_n = 1'b0;
    tick();                 // E2 with reset
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_product", 64'(product), 64'd0);
    rst_n = 1'b1;
    run_op("after_rst", 16'd3, 8'd7, 8'd2, 24'h000017);

    // Round trip on the default DUT: reference division, then rebuild
    for (int i = 0; i < 12; i++) begin
      dv = 8'($urandom_range(1, 255));
      dividend = 24'($urandom % ({8'd0, dv, 16'd0}));
      run_op("rt_n4", 16'(dividend / dv), dv, 8'(dividend % dv), dividend);
    end

    // Round trip on N=1, N=3 (non-dividing) and N=16 variants
    run_multi("mx_max", 16'hFFFF, 8'hFF, 8'hFF, 24'hFF0000);
    run_multi("mx_nom", 16'h1234, 8'h56, 8'h21, 24'h061D99);
    for (int i = 0; i < 8; i++) begin
      dv = 8'($urandom_range(1, 255));
      dividend = 24'($urandom % ({8'd0, dv, 16'd0}));
      run_multi("mx_rt", 16'(dividend / dv), dv, 8'(dividend % dv), dividend);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
